// File: rtl/life_step_ctrl.sv
// In-place Game of Life generation engine for a ROWS x COLS row-per-word grid RAM.
// Keeps original prev/cur/nxt rows in registers so overwriting a row never corrupts its neighbours.

module life_cell (
  input  logic [2:0] up,
  input  logic [2:0] mid,
  input  logic [2:0] dn,
  output logic       alive
);
  logic [3:0] n;

  // mid[1] is the cell itself and is excluded from the count
  assign n = 4'(up[0]) + 4'(up[1]) + 4'(up[2]) + 4'(mid[0]) + 4'(mid[2])
           + 4'(dn[0]) + 4'(dn[1]) + 4'(dn[2]);
  assign alive = (n == 4'd3) | (mid[1] & (n == 4'd2));
endmodule

module life_step_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            ram_req,
  input  logic            ram_gnt,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_wren,
  output logic [COLS-1:0] ram_wdata,
  input  logic [COLS-1:0] ram_q,
  output logic            busy,
  output logic            done,
  output logic            stable,
  output logic [15:0]     gen_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD_FIRST, S_CAP_FIRST, S_RD_NEXT, S_CAP_NEXT, S_WRITE, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [COLS-1:0] prev, cur, nxt, life_row;
  logic [AW-1:0]   r, rd_addr;
  logic            chg, last_row;

  // zero guard columns make the left/right borders dead
  logic [COLS+1:0] pe, ce, ne;
  assign pe = {1'b0, prev, 1'b0};
  assign ce = {1'b0, cur,  1'b0};
  assign ne = {1'b0, nxt,  1'b0};

  for (genvar i = 0; i < COLS; i++) begin : g_cell
    life_cell u_cell (
      .up   (pe[i+2:i]),
      .mid  (ce[i+2:i]),
      .dn   (ne[i+2:i]),
      .alive(life_row[i])
    );
  end

  assign last_row = (r == AW'(ROWS-1));
  // past the last row the read address is held so no out-of-grid word is fetched
  assign rd_addr  = last_row ? r : r + 1'b1;
  assign busy     = (state != S_IDLE);
  assign ram_req  = busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      prev      <= '0;
      cur       <= '0;
      nxt       <= '0;
      r         <= '0;
      chg       <= 1'b0;
      stable    <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_RD_FIRST: begin
          prev <= '0;
          r    <= '0;
          chg  <= 1'b0;
        end
        S_CAP_FIRST: cur <= ram_q;
        S_CAP_NEXT:  nxt <= last_row ? '0 : ram_q;
        S_WRITE: begin
          prev <= cur;
          cur  <= nxt;
          chg  <= chg | (life_row != cur);
          if (!last_row) r <= r + 1'b1;
        end
        S_DONE: begin
          stable    <= ~chg;
          gen_count <= gen_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    done      = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nx = S_REQ;
      S_REQ:       if (ram_gnt) state_nx = S_RD_FIRST;
      S_RD_FIRST:  state_nx = S_CAP_FIRST;
      S_CAP_FIRST: state_nx = S_RD_NEXT;
      S_RD_NEXT: begin
        ram_addr = rd_addr;
        state_nx = S_CAP_NEXT;
      end
      S_CAP_NEXT: begin
        ram_addr = rd_addr;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        ram_addr  = r;
        ram_wren  = 1'b1;
        ram_wdata = life_row;
        state_nx  = last_row ? S_DONE : S_RD_NEXT;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_life_step_ctrl.sv
// Self-checking bench for life_step_ctrl: behavioural RAM, grant model and a cell-by-cell Life reference.

module tb_life_step_ctrl;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            ram_req, ram_gnt, ram_wren, busy, done, stable;
  logic [AW-1:0]   ram_addr;
  logic [COLS-1:0] ram_wdata, ram_q;
  logic [15:0]     gen_count;

  life_step_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ram_req(ram_req), .ram_gnt(ram_gnt),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q),
    .busy(busy), .done(done), .stable(stable), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // synchronous RAM, read-before-write
  logic [COLS-1:0] mem [0:31];
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_wren) mem[ram_addr] <= ram_wdata;
  end

  // arbiter: grant arrives gdelay cycles after ram_req rises
  int gdelay = 0;
  int req_cyc = 0;
  always @(posedge clk) begin
    if (!ram_req) req_cyc <= 0;
    else          req_cyc <= req_cyc + 1;
  end
  assign ram_gnt = ram_req && (req_cyc >= gdelay);

  int wren_tot = 0, bad_addr_tot = 0, act_bad_tot = 0;
  bit granted = 1'b0;
  always @(negedge clk) begin
    if (ram_wren) wren_tot++;
    if (busy && ram_addr >= AW'(ROWS)) bad_addr_tot++;
    if (ram_req && !ram_gnt && (ram_wren || ram_addr != '0)) act_bad_tot++;
    if (!ram_req) granted = 1'b0;
    else if (ram_gnt) granted = 1'b1;
    assert (!(granted && ram_req && !ram_gnt)) else $error("ram_gnt dropped before done");
  end

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [COLS-1:0] g_in [ROWS];
  logic [COLS-1:0] g_exp[ROWS];
  bit exp_stable;

  // reference: count live neighbours cell by cell, anything off-grid is dead
  task automatic model_step();
    exp_stable = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      for (int b = 0; b < COLS; b++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int db = -1; db <= 1; db++) begin
            int rr = r + dr;
            int bb = b + db;
            if (!(dr == 0 && db == 0) && rr >= 0 && rr < ROWS && bb >= 0 && bb < COLS)
              n += int'(g_in[rr][bb]);
          end
        g_exp[r][b] = (n == 3) || (g_in[r][b] && n == 2);
      end
      if (g_exp[r] != g_in[r]) exp_stable = 1'b0;
    end
  endtask

  task automatic load_grid();
    for (int i = 0; i < 32; i++) mem[i] <= (i < ROWS) ? g_in[i] : '0;
    @(negedge clk);
  endtask

  task automatic check_grid(input string tag);
    for (int r = 0; r < ROWS; r++) check($sformatf("%s_row%0d", tag, r), 64'(mem[r]), 64'(g_exp[r]));
  endtask

  task automatic blinker();
    for (int i = 0; i < ROWS; i++) g_in[i] = '0;
    g_in[14] = 40'h0000380000;
  endtask

  // one step from a start pulse; lat = cycles from the start-sampling cycle to DONE
  task automatic run_step(input int gd, input bit spam, output int lat);
    bit got = 1'b0;
    gdelay = gd;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    while (!got && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      start = (spam && lat < 80) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      got = done;
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  int lat, w0, b0, a0, t1, t2, nd, cyc;
  logic [15:0] exp_gc;
  logic [COLS-1:0] orig [ROWS];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(ram_req), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stable", 64'(stable), 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    exp_gc = 16'd0;

    // blinker, two steps back to the original
    blinker(); load_grid(); model_step();
    run_step(0, 1'b0, lat); exp_gc++;
    check("blink_lat", 64'(lat), 64'd94);
    check_grid("blink1");
    check("blink_r13", 64'(mem[13]), 64'h0000100000);
    check("blink_r14", 64'(mem[14]), 64'h0000100000);
    check("blink_r15", 64'(mem[15]), 64'h0000100000);
    check("blink_stable", 64'(stable), 64'(exp_stable));
    check("blink_gen", 64'(gen_count), 64'(exp_gc));
    for (int i = 0; i < ROWS; i++) g_in[i] = g_exp[i];
    model_step();
    run_step(0, 1'b0, lat); exp_gc++;
    check_grid("blink2");
    check("blink2_r14", 64'(mem[14]), 64'h0000380000);
    check("blink2_gen", 64'(gen_count), 64'(exp_gc));

    // corner block: still life
    for (int i = 0; i < ROWS; i++) g_in[i] = '0;
    g_in[0] = 40'hC000000000; g_in[1] = 40'hC000000000;
    load_grid(); model_step();
    w0 = wren_tot; b0 = bad_addr_tot;
    run_step(0, 1'b0, lat); exp_gc++;
    check_grid("corner");
    check("corner_stable", 64'(stable), 64'd1);
    check("corner_wren", 64'(wren_tot - w0), 64'd30);
    check("corner_addr30", 64'(bad_addr_tot - b0), 64'd0);

    // all ones: dead border and full 8-neighbour count
    for (int i = 0; i < ROWS; i++) g_in[i] = '1;
    load_grid(); model_step();
    run_step(0, 1'b0, lat); exp_gc++;
    check_grid("ones");
    check("ones_r0", 64'(mem[0]), 64'h8000000001);
    check("ones_r29", 64'(mem[29]), 64'h8000000001);
    check("ones_r15", 64'(mem[15]), 64'h0);

    // grant delayed 7 cycles
    blinker(); load_grid(); model_step();
    a0 = act_bad_tot;
    run_step(7, 1'b0, lat); exp_gc++;
    check("gdly_lat", 64'(lat), 64'd101);
    check("gdly_quiet", 64'(act_bad_tot - a0), 64'd0);
    check_grid("gdly");

    // start toggled while busy: one generation only
    blinker(); load_grid(); model_step();
    run_step(2, 1'b1, lat); exp_gc++;
    repeat (5) @(negedge clk);
    check("spam_busy", 64'(busy), 64'd0);
    check("spam_gen", 64'(gen_count), 64'(exp_gc));
    check_grid("spam");

    // start held high: back-to-back steps with one IDLE cycle between
    blinker();
    for (int i = 0; i < ROWS; i++) orig[i] = g_in[i];
    load_grid();
    gdelay = 0;
    @(negedge clk);
    start = 1'b1; cyc = 0; nd = 0; t1 = 0; t2 = 0;
    while (nd < 2 && cyc < 500) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done) begin nd++; if (nd == 1) t1 = cyc; else t2 = cyc; end
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_gc += 16'd2;
    check("held_first", 64'(t1), 64'd94);
    check("held_gap", 64'(t2 - t1), 64'd95);
    check("held_gen", 64'(gen_count), 64'(exp_gc));
    for (int i = 0; i < ROWS; i++) g_exp[i] = orig[i];
    check_grid("held");

    // random grids with random grant delay
    for (int k = 0; k < 4; k++) begin
      int gd = $urandom_range(0, 5);
      for (int i = 0; i < ROWS; i++) g_in[i] = {$urandom, $urandom} & {$urandom, $urandom};
      load_grid(); model_step();
      run_step(gd, 1'b0, lat); exp_gc++;
      check($sformatf("rnd%0d_lat", k), 64'(lat), 64'(94 + gd));
      check_grid($sformatf("rnd%0d", k));
      check($sformatf("rnd%0d_stable", k), 64'(stable), 64'(exp_stable));
      check($sformatf("rnd%0d_gen", k), 64'(gen_count), 64'(exp_gc));
    end

    // asynchronous reset while writing row 10
    for (int i = 0; i < ROWS; i++) g_in[i] = {$urandom, $urandom};
    load_grid();
    gdelay = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!(ram_wren && ram_addr == 5'd10) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("rst_mid_reached", 64'(cyc < 200), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_req", 64'(ram_req), 64'd0);
    check("rstm_wren", 64'(ram_wren), 64'd0);
    check("rstm_addr", 64'(ram_addr), 64'd0);
    check("rstm_wdata", 64'(ram_wdata), 64'd0);
    check("rstm_gen", 64'(gen_count), 64'd0);
    check("rstm_stable", 64'(stable), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) g_in[i] = mem[i];
    model_step();
    run_step(0, 1'b0, lat);
    check("rstm_lat", 64'(lat), 64'd94);
    check_grid("rstm");
    check("rstm_gen1", 64'(gen_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
